// File: rtl/csr_cmd_initiator.sv
// CSR command initiator: queues write/read/poll commands, issues them one at a
// time on the CSR valid/ready request port, and returns read/poll results.
module csr_cmd_initiator #(
   parameter int CSR_WIDTH      = 32,
   parameter int CSR_ADDR_WIDTH = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int POLL_MAX       = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [1:0]                cmd_op_i,
   input  logic [CSR_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [CSR_WIDTH-1:0]      cmd_data_i,
   input  logic [CSR_WIDTH-1:0]      cmd_mask_i,
   output logic                      res_valid_o,
   input  logic                      res_ready_i,
   output logic [CSR_WIDTH-1:0]      res_data_o,
   output logic                      res_err_o,
   output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
   output logic [CSR_WIDTH-1:0]      csr_wr_data_o,
   output logic                      csr_wr_en_o,
   output logic                      csr_req_valid_o,
   input  logic                      csr_req_ready_i,
   input  logic [CSR_WIDTH-1:0]      csr_rd_data_i,
   input  logic                      csr_rsp_valid_i,
   output logic                      csr_rsp_ready_o,
   output logic                      idle_o
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int POLL_W = $clog2(POLL_MAX + 1);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_POLL  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP, ST_RES} state_t;

   state_t state_reg, state_next;

   // Command FIFO storage (no reset: contents are only valid under count_reg)
   logic [1:0]                fifo_op   [FIFO_DEPTH];
   logic [CSR_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
   logic [CSR_WIDTH-1:0]      fifo_data [FIFO_DEPTH];
   logic [CSR_WIDTH-1:0]      fifo_mask [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   // Command register: the entry currently owned by the FSM
   logic [1:0]                op_reg;
   logic [CSR_ADDR_WIDTH-1:0] addr_reg;
   logic [CSR_WIDTH-1:0]      data_reg;
   logic [CSR_WIDTH-1:0]      mask_reg;
   logic [POLL_W-1:0]         poll_cnt_reg;
   logic [CSR_WIDTH-1:0]      res_data_reg;
   logic                      res_err_reg;

   logic fifo_full, fifo_empty, push, pop;
   logic poll_match, poll_last, rsp_hs;

   assign fifo_full   = (count_reg == CNT_W'(FIFO_DEPTH));
   assign fifo_empty  = (count_reg == '0);
   assign cmd_ready_o = !fifo_full;
   assign push        = cmd_valid_i && !fifo_full;
   assign pop         = (state_reg == ST_IDLE) && !fifo_empty;
   assign idle_o      = fifo_empty && (state_reg == ST_IDLE);
   assign rsp_hs      = (state_reg == ST_RSP) && csr_rsp_valid_i;
   assign poll_match  = ((csr_rd_data_i ^ data_reg) & mask_reg) == '0;
   // Counter holds completed mismatching attempts; this attempt is the last one
   assign poll_last   = (poll_cnt_reg == POLL_W'(POLL_MAX - 1));

   // FIFO storage write on push
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_op[wr_ptr_reg]   <= cmd_op_i;
         fifo_addr[wr_ptr_reg] <= cmd_addr_i;
         fifo_data[wr_ptr_reg] <= cmd_data_i;
         fifo_mask[wr_ptr_reg] <= cmd_mask_i;
      end
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   // FSM next-state logic; the head opcode is peeked so reserved ops skip REQ
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty)
               state_next = (fifo_op[rd_ptr_reg] == OP_RSVD) ? ST_RES : ST_REQ;
         end
         ST_REQ: begin
            if (csr_req_ready_i) state_next = ST_RSP;
         end
         ST_RSP: begin
            if (csr_rsp_valid_i) begin
               case (op_reg)
                  OP_WRITE: state_next = ST_IDLE;
                  OP_POLL:  state_next = (poll_match || poll_last) ? ST_RES : ST_REQ;
                  default:  state_next = ST_RES;
               endcase
            end
         end
         ST_RES: begin
            if (res_ready_i) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM outputs; request/result fields are zero outside their own states
   always_comb begin
      csr_req_valid_o = 1'b0;
      csr_addr_o      = '0;
      csr_wr_data_o   = '0;
      csr_wr_en_o     = 1'b0;
      csr_rsp_ready_o = 1'b0;
      res_valid_o     = 1'b0;
      res_data_o      = '0;
      res_err_o       = 1'b0;
      case (state_reg)
         ST_REQ: begin
            csr_req_valid_o = 1'b1;
            csr_addr_o      = addr_reg;
            csr_wr_data_o   = data_reg;
            csr_wr_en_o     = (op_reg == OP_WRITE);
         end
         ST_RSP: csr_rsp_ready_o = 1'b1;
         ST_RES: begin
            res_valid_o = 1'b1;
            res_data_o  = res_data_reg;
            res_err_o   = res_err_reg;
         end
         default: ;
      endcase
   end

   // Command register load, poll attempt counter and result capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_reg       <= '0;
         addr_reg     <= '0;
         data_reg     <= '0;
         mask_reg     <= '0;
         poll_cnt_reg <= '0;
         res_data_reg <= '0;
         res_err_reg  <= 1'b0;
      end else begin
         if (pop) begin
            op_reg       <= fifo_op[rd_ptr_reg];
            addr_reg     <= fifo_addr[rd_ptr_reg];
            data_reg     <= fifo_data[rd_ptr_reg];
            mask_reg     <= fifo_mask[rd_ptr_reg];
            poll_cnt_reg <= '0;
            if (fifo_op[rd_ptr_reg] == OP_RSVD) begin
               res_data_reg <= '0;
               res_err_reg  <= 1'b1;
            end
         end
         if (rsp_hs) begin
            if (op_reg == OP_READ) begin
               res_data_reg <= csr_rd_data_i;
               res_err_reg  <= 1'b0;
            end else if (op_reg == OP_POLL) begin
               if (poll_match) begin
                  res_data_reg <= csr_rd_data_i;
                  res_err_reg  <= 1'b0;
               end else begin
                  poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
                  if (poll_last) begin
                     res_data_reg <= csr_rd_data_i;
                     res_err_reg  <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_csr_cmd_initiator.sv
// Bench for csr_cmd_initiator: memory-model responder with programmable
// stalls/delays and scripted read data, plus a result scoreboard.
module tb_csr_cmd_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_addr, cmd_data, cmd_mask;
   logic        res_valid, res_ready, res_err;
   logic [31:0] res_data;
   logic [31:0] csr_addr, csr_wr_data, csr_rd_data;
   logic        csr_wr_en, csr_req_valid, csr_req_ready;
   logic        csr_rsp_valid, csr_rsp_ready, idle;

   csr_cmd_initiator dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
      .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
      .res_err_o(res_err), .csr_addr_o(csr_addr), .csr_wr_data_o(csr_wr_data),
      .csr_wr_en_o(csr_wr_en), .csr_req_valid_o(csr_req_valid),
      .csr_req_ready_i(csr_req_ready), .csr_rd_data_i(csr_rd_data),
      .csr_rsp_valid_i(csr_rsp_valid), .csr_rsp_ready_o(csr_rsp_ready),
      .idle_o(idle)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s got=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   // Responder model state
   logic [31:0] mem [logic [31:0]];
   logic [31:0] rd_script[$];
   logic [31:0] log_addr[$], log_data[$];
   logic        log_wr[$];
   int stall_cfg = 0, delay_cfg = 0;
   int hs_count = 0, last_hs_cyc = 0;

   // Monitor state
   int res_cnt = 0, rv_cyc = 0, last_lat = 0, both_cnt = 0;

   // Responder: decides at negedge+1 what the next posedge will see
   initial begin
      int rphase, stall_left, delay_left;
      bit first;
      logic [31:0] lat_addr, lat_data, rsp_val;
      logic lat_wr;
      rphase = 0; stall_left = 0; delay_left = 0; first = 0;
      lat_addr = '0; lat_data = '0; lat_wr = 0; rsp_val = '0;
      csr_req_ready = 0; csr_rsp_valid = 0; csr_rd_data = '0;
      forever begin
         @(negedge clk); #1;
         if (rst) begin
            rphase = 0; csr_req_ready = 0; csr_rsp_valid = 0;
            continue;
         end
         if (rphase == 3) begin
            csr_rsp_valid = 0;
            rphase = 0;
         end
         if (rphase == 2) begin
            csr_req_ready = 0;
            if (delay_left > 0) begin
               delay_left--;
               chk("rsp_ready_while_waiting", csr_rsp_ready, 1);
            end else begin
               csr_rsp_valid = 1;
               csr_rd_data = rsp_val;
               rphase = 3;
            end
         end
         if (rphase == 0 && csr_req_valid) begin
            lat_addr = csr_addr; lat_data = csr_wr_data; lat_wr = csr_wr_en;
            stall_left = stall_cfg;
            first = 1;
            rphase = 1;
         end
         if (rphase == 1) begin
            if (!first) begin
               chk("stall_addr_stable", csr_addr, lat_addr);
               chk("stall_data_stable", csr_wr_data, lat_data);
               chk("stall_wren_stable", csr_wr_en, lat_wr);
            end
            first = 0;
            if (stall_left > 0) begin
               stall_left--;
               csr_req_ready = 0;
            end else begin
               csr_req_ready = 1;
               hs_count++;
               last_hs_cyc = cyc;
               log_addr.push_back(csr_addr);
               log_data.push_back(csr_wr_data);
               log_wr.push_back(csr_wr_en);
               if (csr_wr_en) begin
                  mem[csr_addr] = csr_wr_data;
                  rsp_val = 32'h0BAD_F00D;
               end else if (rd_script.size() > 0) begin
                  rsp_val = rd_script.pop_front();
               end else begin
                  rsp_val = mem.exists(csr_addr) ? mem[csr_addr] : 32'h0;
               end
               delay_left = delay_cfg;
               rphase = 2;
            end
         end
      end
   end

   // Result monitor / scoreboard compare at negedge+2
   initial begin
      bit prev_rv;
      exp_t e;
      prev_rv = 0;
      forever begin
         @(negedge clk); #2;
         if (rst) begin
            prev_rv = 0;
            continue;
         end
         if (csr_req_valid && csr_rsp_ready) both_cnt++;
         if (res_valid && !prev_rv) rv_cyc = cyc;
         prev_rv = res_valid;
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               $display("result data=0x%08h err=%0b expected data=0x%08h err=%0b", res_data, res_err, e.data, e.err);
               chk("res_data", res_data, e.data);
               chk("res_err", res_err, e.err);
               last_lat = rv_cyc - last_hs_cyc;
               res_cnt++;
            end
            prev_rv = 0;
         end
      end
   end

   // Drive one command; returns at the negedge after it was accepted
   task automatic push_cmd(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] mask,
                           input bit has_res, input logic [31:0] edata, input logic eerr);
      int n;
      cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("push_timeout", 0, 1);
      @(negedge clk);
      cmd_valid = 0;
      $display("cmd op=%0d addr=0x%08h data=0x%08h mask=0x%08h", op, addr, data, mask);
      if (has_res) exp_q.push_back('{data: edata, err: eerr});
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(idle && exp_q.size() == 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, (n < 2000), 1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_idle", idle, 1);
      chk("rst_req_valid", csr_req_valid, 0);
      chk("rst_rsp_ready", csr_rsp_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_csr_addr", csr_addr, 0);
      chk("rst_csr_wdata", csr_wr_data, 0);
      chk("rst_csr_wren", csr_wr_en, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0, rc0, n;
      rst = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_mask = 0;
      res_ready = 1;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 0;
      @(negedge clk);

      // Write then read with latency checks
      hs0 = hs_count; rc0 = res_cnt;
      push_cmd(2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0);
      chk("lat_req_c1", csr_req_valid, 0);
      @(negedge clk);
      chk("lat_req_c2", csr_req_valid, 1);
      push_cmd(2'b01, 32'h10, 32'h0, 32'h0, 1, 32'hDEADBEEF, 0);
      wait_idle("wr_rd_done");
      chk("wr_rd_hs_count", hs_count - hs0, 2);
      chk("wr_hs_wren", log_wr[hs0], 1);
      chk("wr_hs_data", log_data[hs0], 32'hDEADBEEF);
      chk("wr_hs_addr", log_addr[hs0], 32'h10);
      chk("rd_hs_wren", log_wr[hs0 + 1], 0);
      chk("rd_hs_addr", log_addr[hs0 + 1], 32'h10);
      chk("wr_rd_results", res_cnt - rc0, 1);
      chk("rd_result_latency", last_lat, 2);

      // Back-pressure on request and delayed response
      stall_cfg = 5; delay_cfg = 3;
      hs0 = hs_count;
      push_cmd(2'b00, 32'h20, 32'h12345678, 32'h0, 0, 0, 0);
      wait_idle("bp_write_done");
      chk("bp_hs_count", hs_count - hs0, 1);
      stall_cfg = 0; delay_cfg = 0;
      push_cmd(2'b01, 32'h20, 32'h0, 32'h0, 1, 32'h12345678, 0);
      wait_idle("bp_read_done");

      // Poll success on third read
      rd_script = '{32'h0, 32'h0, 32'h3};
      hs0 = hs_count;
      push_cmd(2'b10, 32'h40, 32'h1, 32'h1, 1, 32'h3, 0);
      wait_idle("poll_ok_done");
      chk("poll_ok_reads", hs_count - hs0, 3);

      // Poll timeout
      mem[32'h44] = 32'h0;
      hs0 = hs_count;
      push_cmd(2'b10, 32'h44, 32'h1, 32'h1, 1, 32'h0, 1);
      wait_idle("poll_to_done");
      chk("poll_to_reads", hs_count - hs0, 16);

      // Reserved opcode: error result, no CSR traffic
      hs0 = hs_count;
      push_cmd(2'b11, 32'h50, 32'h77, 32'h0, 1, 32'h0, 1);
      wait_idle("rsvd_done");
      chk("rsvd_no_request", hs_count - hs0, 0);

      // FIFO fill behind a stalled result
      for (int i = 0; i < 5; i++) mem[32'h100 + 4 * i] = 32'hA500_0000 + i;
      res_ready = 0;
      for (int i = 0; i < 5; i++)
         push_cmd(2'b01, 32'h100 + 4 * i, 32'h0, 32'h0, 1, 32'hA500_0000 + i, 0);
      repeat (4) @(negedge clk);
      chk("full_cmd_ready", cmd_ready, 0);
      chk("full_idle", idle, 0);
      chk("full_res_valid", res_valid, 1);
      res_ready = 1;
      wait_idle("full_drain_done");
      chk("full_idle_after", idle, 1);

      // Reset while a request is stalled
      stall_cfg = 1000;
      push_cmd(2'b01, 32'h10, 32'h0, 32'h0, 1, 32'hDEADBEEF, 0);
      n = 0;
      while (!csr_req_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("midreq_reached", csr_req_valid, 1);
      rst = 1;
      @(negedge clk);
      check_reset_outputs();
      rst = 0;
      void'(exp_q.pop_back());
      stall_cfg = 0;
      mem[32'h30] = 32'hCAFE0030;
      push_cmd(2'b01, 32'h30, 32'h0, 32'h0, 1, 32'hCAFE0030, 0);
      wait_idle("after_reset_done");

      chk("req_and_rsp_never_both", both_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
